div_reservation_station: RTL and testbench

Reservation station directly upstream of the divide unit. Accepts dispatched divide instructions whose operands are either values or producer tags, snoops the common data bus (CDB) to capture pending operands, and issues ready entries through a registered valid/ready output to the divider. Each entry owns a fixed result tag. The entry stays allocated until its own result is broadcast on the CDB, so a tag is never reused while it is in flight.

---
 rtl/div_reservation_station_if.sv | 58 +++++
 rtl/div_reservation_station.sv | 172 +++++++++++++++++
 tb/tb_div_reservation_station.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_reservation_station_if.sv
// Divide reservation station: shared decode type and the bundled
// dispatch / CDB / issue interface. The station uses the slave modport;
// the dispatcher/CDB/divider side uses the master modport.
package div_rs_pkg;
  // Decode bits that travel with a divide instruction to the divider.
  typedef struct packed {
    logic is_signed;
    logic want_rem;
  } div_decode_t;
endpackage

interface div_reservation_station_if #(
  parameter int RS_ID_WIDTH = 5
);
  import div_rs_pkg::*;

  // Dispatch side
  logic                   dispatch_valid;
  logic                   dispatch_ready;
  logic [31:0]            op1_value;
  logic [31:0]            op2_value;
  logic                   op1_present;
  logic                   op2_present;
  logic [RS_ID_WIDTH-1:0] op1_rs_id;
  logic [RS_ID_WIDTH-1:0] op2_rs_id;
  logic [4:0]             result_reg_addr_in;
  div_decode_t            control_in;

  // Common data bus snoop
  logic                   cdb_valid;
  logic [RS_ID_WIDTH-1:0] cdb_rs_id;
  logic [31:0]            cdb_result;

  // Issue side towards the divider
  logic                   issue_valid;
  logic                   issue_ready;
  logic [RS_ID_WIDTH-1:0] rs_id_out;
  logic [4:0]             result_reg_addr_out;
  logic [31:0]            op1;
  logic [31:0]            op2;
  div_decode_t            control_out;

  modport slave (
    input  dispatch_valid, op1_value, op2_value, op1_present, op2_present,
           op1_rs_id, op2_rs_id, result_reg_addr_in, control_in,
           cdb_valid, cdb_rs_id, cdb_result, issue_ready,
    output dispatch_ready, issue_valid, rs_id_out, result_reg_addr_out,
           op1, op2, control_out
  );

  modport master (
    output dispatch_valid, op1_value, op2_value, op1_present, op2_present,
           op1_rs_id, op2_rs_id, result_reg_addr_in, control_in,
           cdb_valid, cdb_rs_id, cdb_result, issue_ready,
    input  dispatch_ready, issue_valid, rs_id_out, result_reg_addr_out,
           op1, op2, control_out
  );
endinterface

// File: rtl/div_reservation_station.sv
// Reservation station in front of the divide unit. Entry i owns result tag
// RS_BASE_ID+i and stays allocated until that tag is broadcast on the CDB.
// Optional feature: define DIV_RS_DISPATCH_BYPASS_EN to capture a CDB value
// that arrives in the same cycle as the dispatch of its consumer; without it
// dispatch stalls for that cycle instead.
module div_reservation_station
  import div_rs_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int NUM_ENTRIES = 4,
  parameter int RS_BASE_ID  = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  div_reservation_station_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {S_EMPTY, S_WAITING, S_READY, S_ISSUED} state_t;

  state_t                 r_state [NUM_ENTRIES];
  logic [31:0]            r_op1   [NUM_ENTRIES];
  logic [31:0]            r_op2   [NUM_ENTRIES];
  logic                   r_pend1 [NUM_ENTRIES];
  logic                   r_pend2 [NUM_ENTRIES];
  logic [RS_ID_WIDTH-1:0] r_tag1  [NUM_ENTRIES];
  logic [RS_ID_WIDTH-1:0] r_tag2  [NUM_ENTRIES];
  logic [4:0]             r_addr  [NUM_ENTRIES];
  div_decode_t            r_ctrl  [NUM_ENTRIES];

  logic                   r_issue_valid;
  logic [RS_ID_WIDTH-1:0] r_issue_id;
  logic [4:0]             r_issue_addr;
  logic [31:0]            r_issue_op1;
  logic [31:0]            r_issue_op2;
  div_decode_t            r_issue_ctrl;

  logic                   w_free_found, w_sel_found;
  logic [IDX_W-1:0]       w_free_idx, w_sel_idx;
  logic [NUM_ENTRIES-1:0] w_wake1, w_wake2, w_release;
  logic                   w_hit1, w_hit2, w_in_p1, w_in_p2, w_stall;
  logic [31:0]            w_in_v1, w_in_v2;
  logic                   w_dispatch_fire, w_issue_fire;

  // Lowest-index free and ready entries, plus per-entry CDB wakeup/release.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_sel_found  = 1'b0;
    w_sel_idx    = '0;
    w_wake1      = '0;
    w_wake2      = '0;
    w_release    = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (r_state[i] == S_EMPTY) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (r_state[i] == S_READY) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
      w_wake1[i]   = bus.cdb_valid && (r_state[i] == S_WAITING) && r_pend1[i]
                     && (r_tag1[i] == bus.cdb_rs_id);
      w_wake2[i]   = bus.cdb_valid && (r_state[i] == S_WAITING) && r_pend2[i]
                     && (r_tag2[i] == bus.cdb_rs_id);
      w_release[i] = bus.cdb_valid && (r_state[i] == S_ISSUED)
                     && (bus.cdb_rs_id == RS_ID_WIDTH'(RS_BASE_ID + i));
    end
  end

  // Incoming operands checked against a same-cycle CDB broadcast.
  always_comb begin
    w_hit1 = bus.cdb_valid && !bus.op1_present && (bus.op1_rs_id == bus.cdb_rs_id);
    w_hit2 = bus.cdb_valid && !bus.op2_present && (bus.op2_rs_id == bus.cdb_rs_id);
`ifdef DIV_RS_DISPATCH_BYPASS_EN
    w_in_p1 = bus.op1_present || w_hit1;
    w_in_p2 = bus.op2_present || w_hit2;
    w_stall = 1'b0;
`else
    w_in_p1 = bus.op1_present;
    w_in_p2 = bus.op2_present;
    w_stall = w_hit1 || w_hit2;
`endif
    w_in_v1 = w_hit1 ? bus.cdb_result : bus.op1_value;
    w_in_v2 = w_hit2 ? bus.cdb_result : bus.op2_value;
  end

  assign bus.dispatch_ready = w_free_found && !w_stall;
  assign w_dispatch_fire    = bus.dispatch_valid && bus.dispatch_ready;
  assign w_issue_fire       = w_sel_found && (!r_issue_valid || bus.issue_ready);

  // Per-entry lifecycle: EMPTY -> WAITING/READY -> ISSUED -> EMPTY on own tag.
  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every entry sees pre-edge values.
    if (!i_rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_state[i] <= S_EMPTY;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        case (r_state[i])
          S_EMPTY:
            if (w_dispatch_fire && (w_free_idx == IDX_W'(i)))
              r_state[i] <= (w_in_p1 && w_in_p2) ? S_READY : S_WAITING;
          S_WAITING:
            if ((!r_pend1[i] || w_wake1[i]) && (!r_pend2[i] || w_wake2[i]))
              r_state[i] <= S_READY;
          S_READY:
            if (w_issue_fire && (w_sel_idx == IDX_W'(i)))
              r_state[i] <= S_ISSUED;
          S_ISSUED:
            if (w_release[i]) r_state[i] <= S_EMPTY;
          default: r_state[i] <= S_EMPTY;
        endcase
      end
    end
  end

  // Entry payload: written on dispatch, operands patched on CDB wakeup.
  always_ff @(posedge i_clk) begin
    // NOTE: payload storage is not reset; an EMPTY state makes its contents irrelevant.
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (r_state[i] == S_EMPTY && w_dispatch_fire && (w_free_idx == IDX_W'(i))) begin
        r_op1[i]   <= w_in_v1;
        r_op2[i]   <= w_in_v2;
        r_pend1[i] <= !w_in_p1;
        r_pend2[i] <= !w_in_p2;
        r_tag1[i]  <= bus.op1_rs_id;
        r_tag2[i]  <= bus.op2_rs_id;
        r_addr[i]  <= bus.result_reg_addr_in;
        r_ctrl[i]  <= bus.control_in;
      end else begin
        if (w_wake1[i]) begin
          r_op1[i]   <= bus.cdb_result;
          r_pend1[i] <= 1'b0;
        end
        if (w_wake2[i]) begin
          r_op2[i]   <= bus.cdb_result;
          r_pend2[i] <= 1'b0;
        end
      end
    end
  end

  // Issue register: loads the selected entry, holds while the divider stalls.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_issue_valid <= 1'b0;
      r_issue_id    <= '0;
      r_issue_addr  <= '0;
      r_issue_op1   <= '0;
      r_issue_op2   <= '0;
      r_issue_ctrl  <= '0;
    end else if (w_issue_fire) begin
      r_issue_valid <= 1'b1;
      r_issue_id    <= RS_ID_WIDTH'(RS_BASE_ID) + RS_ID_WIDTH'(w_sel_idx);
      r_issue_addr  <= r_addr[w_sel_idx];
      r_issue_op1   <= r_op1[w_sel_idx];
      r_issue_op2   <= r_op2[w_sel_idx];
      r_issue_ctrl  <= r_ctrl[w_sel_idx];
    end else if (bus.issue_ready) begin
      r_issue_valid <= 1'b0;
    end
  end

  assign bus.issue_valid         = r_issue_valid;
  assign bus.rs_id_out           = r_issue_id;
  assign bus.result_reg_addr_out = r_issue_addr;
  assign bus.op1                 = r_issue_op1;
  assign bus.op2                 = r_issue_op2;
  assign bus.control_out         = r_issue_ctrl;
endmodule

// File: tb/tb_div_reservation_station.sv
// Self-checking bench for div_reservation_station: directed scenarios
// followed by randomized traffic, all compared against a slot-table model.
module tb_div_reservation_station;
  import div_rs_pkg::*;

  localparam int NE   = 4;
  localparam int BASE = 0;
  localparam int W    = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_reservation_station_if #(.RS_ID_WIDTH(W)) bus ();

  div_reservation_station #(
    .RS_ID_WIDTH(W), .NUM_ENTRIES(NE), .RS_BASE_ID(BASE)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .bus(bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a table of occupied slots with operand availability flags
  // and a separate record of what the divider port is presenting.
  typedef struct {
    bit          busy;
    bit          issued;
    bit          have1, have2;
    logic [31:0] v1, v2;
    logic [W-1:0] t1, t2;
    logic [4:0]  addr;
    div_decode_t ctrl;
  } slot_t;

  slot_t        m_slot [NE];
  bit           m_iv;
  logic [W-1:0] m_id;
  logic [4:0]   m_addr;
  logic [31:0]  m_op1, m_op2;
  div_decode_t  m_ctrl;

  task automatic model_reset();
    for (int i = 0; i < NE; i++) m_slot[i] = '{default: '0};
    m_iv = 0; m_id = '0; m_addr = '0; m_op1 = '0; m_op2 = '0; m_ctrl = '0;
  endtask

  function automatic bit model_dready();
    bit free  = 0;
    bit stall = 0;
    for (int i = 0; i < NE; i++) if (!m_slot[i].busy) free = 1;
`ifndef DIV_RS_DISPATCH_BYPASS_EN
    stall = bus.cdb_valid &&
            ((!bus.op1_present && bus.op1_rs_id == bus.cdb_rs_id) ||
             (!bus.op2_present && bus.op2_rs_id == bus.cdb_rs_id));
`endif
    return free && !stall;
  endfunction

  // One clock: check dispatch_ready, advance the model, check issue outputs.
  task automatic step();
    slot_t nx [NE];
    bit    exp_rdy, fire, h1, h2;
    int    sel, fr;
    #1;
    exp_rdy = model_dready();
    check("dispatch_ready", bus.dispatch_ready, exp_rdy);
    nx  = m_slot;
    sel = -1;
    for (int i = 0; i < NE; i++)
      if (sel < 0 && m_slot[i].busy && !m_slot[i].issued && m_slot[i].have1 && m_slot[i].have2)
        sel = i;
    fire = (sel >= 0) && (!m_iv || bus.issue_ready);
    if (fire) begin
      nx[sel].issued = 1;
      m_iv = 1; m_id = W'(BASE + sel); m_addr = m_slot[sel].addr;
      m_op1 = m_slot[sel].v1; m_op2 = m_slot[sel].v2; m_ctrl = m_slot[sel].ctrl;
    end else if (bus.issue_ready) begin
      m_iv = 0;
    end
    if (bus.cdb_valid) begin
      for (int i = 0; i < NE; i++) begin
        if (m_slot[i].busy && m_slot[i].issued) begin
          if (bus.cdb_rs_id == W'(BASE + i)) nx[i].busy = 0;
        end else if (m_slot[i].busy) begin
          if (!m_slot[i].have1 && m_slot[i].t1 == bus.cdb_rs_id) begin
            nx[i].have1 = 1; nx[i].v1 = bus.cdb_result;
          end
          if (!m_slot[i].have2 && m_slot[i].t2 == bus.cdb_rs_id) begin
            nx[i].have2 = 1; nx[i].v2 = bus.cdb_result;
          end
        end
      end
    end
    if (bus.dispatch_valid && exp_rdy) begin
      fr = -1;
      for (int i = 0; i < NE; i++) if (fr < 0 && !m_slot[i].busy) fr = i;
      h1 = bus.cdb_valid && !bus.op1_present && bus.op1_rs_id == bus.cdb_rs_id;
      h2 = bus.cdb_valid && !bus.op2_present && bus.op2_rs_id == bus.cdb_rs_id;
      nx[fr].busy   = 1;
      nx[fr].issued = 0;
      nx[fr].have1  = bus.op1_present || h1;
      nx[fr].have2  = bus.op2_present || h2;
      nx[fr].v1     = bus.op1_present ? bus.op1_value : bus.cdb_result;
      nx[fr].v2     = bus.op2_present ? bus.op2_value : bus.cdb_result;
      nx[fr].t1     = bus.op1_rs_id;
      nx[fr].t2     = bus.op2_rs_id;
      nx[fr].addr   = bus.result_reg_addr_in;
      nx[fr].ctrl   = bus.control_in;
    end
    @(posedge clk);
    #1;
    m_slot = nx;
    check("issue_valid", bus.issue_valid, m_iv);
    if (m_iv) begin
      check("rs_id_out", bus.rs_id_out, m_id);
      check("result_reg_addr_out", bus.result_reg_addr_out, m_addr);
      check("op1", bus.op1, m_op1);
      check("op2", bus.op2, m_op2);
      check("control_out", bus.control_out, m_ctrl);
    end
  endtask

  task automatic clear_inputs();
    bus.dispatch_valid = 0;
    bus.cdb_valid      = 0;
  endtask

  task automatic drive_disp(input logic [31:0] a, input bit ap, input logic [W-1:0] at,
                            input logic [31:0] b, input bit bp, input logic [W-1:0] bt,
                            input logic [4:0] addr, input div_decode_t c);
    bus.dispatch_valid = 1;
    bus.op1_value = a; bus.op1_present = ap; bus.op1_rs_id = at;
    bus.op2_value = b; bus.op2_present = bp; bus.op2_rs_id = bt;
    bus.result_reg_addr_in = addr;
    bus.control_in = c;
  endtask

  task automatic drive_cdb(input logic [W-1:0] tag, input logic [31:0] val);
    bus.cdb_valid  = 1;
    bus.cdb_rs_id  = tag;
    bus.cdb_result = val;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    check("rst_issue_valid", bus.issue_valid, 0);
    check("rst_rs_id_out", bus.rs_id_out, 0);
    check("rst_addr_out", bus.result_reg_addr_out, 0);
    check("rst_op1", bus.op1, 0);
    check("rst_op2", bus.op2, 0);
    check("rst_control_out", bus.control_out, 0);
    check("rst_dispatch_ready", bus.dispatch_ready, 1);
  endtask

  initial begin
    bus.dispatch_valid = 0; bus.cdb_valid = 0; bus.issue_ready = 1;
    bus.op1_value = '0; bus.op2_value = '0; bus.op1_present = 1; bus.op2_present = 1;
    bus.op1_rs_id = '0; bus.op2_rs_id = '0; bus.result_reg_addr_in = '0;
    bus.control_in = '0; bus.cdb_rs_id = '0; bus.cdb_result = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Both operands present: issue two edges after dispatch.
    drive_disp(100, 1, 0, 7, 1, 0, 5'd3, 2'b01);
    step();
    clear_inputs();
    step();
    check("t1_issue_valid", bus.issue_valid, 1);
    check("t1_rs_id", bus.rs_id_out, 0);
    check("t1_op1", bus.op1, 100);
    check("t1_op2", bus.op2, 7);
    drive_cdb(0, 32'hDEAD);
    #1 check("t1_ready_during_release", bus.dispatch_ready, 1);
    step();
    clear_inputs();
    step();

    // op2 waits on tag 9; broadcast arrives two cycles later.
    drive_disp(50, 1, 0, 0, 0, 9, 5'd7, 2'b10);
    step();
    clear_inputs();
    step();
    drive_cdb(9, 32'h3);
    step();
    clear_inputs();
    step();
    check("t2_issue_valid", bus.issue_valid, 1);
    check("t2_op2", bus.op2, 3);
    drive_cdb(0, 1);
    step();
    clear_inputs();
    step();

    // Fill every entry with a pending operand.
    for (int k = 0; k < NE; k++) begin
      drive_disp(k, 1, 0, 0, 0, W'(20 + k), 5'(k), 2'b00);
      step();
    end
    clear_inputs();
    #1 check("t3_full", bus.dispatch_ready, 0);
    drive_cdb(1, 32'h55);
    step();
    clear_inputs();
    #1 check("t3_still_full", bus.dispatch_ready, 0);
    for (int k = 0; k < NE; k++) begin
      drive_cdb(W'(20 + k), 32'(k * 11 + 1));
      step();
    end
    clear_inputs();
    repeat (6) step();
    for (int k = 0; k < NE; k++) begin
      drive_cdb(W'(BASE + k), 0);
      step();
    end
    clear_inputs();
    step();

    // Divider stalled with two ready entries; outputs must hold entry 0.
    bus.issue_ready = 0;
    drive_disp(11, 1, 0, 22, 1, 0, 5'd1, 2'b01);
    step();
    drive_disp(33, 1, 0, 44, 1, 0, 5'd2, 2'b11);
    step();
    clear_inputs();
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_hold_rs_id", bus.rs_id_out, 0);
      check("t4_hold_op1", bus.op1, 11);
    end
    bus.issue_ready = 1;
    step();
    check("t4_next_rs_id", bus.rs_id_out, 1);
    check("t4_next_op1", bus.op1, 33);
    step();
    drive_cdb(0, 0);
    step();
    drive_cdb(1, 0);
    step();
    clear_inputs();
    step();

    // Same-cycle broadcast of a tag the dispatched instruction waits on.
    drive_disp(5, 1, 0, 0, 0, 9, 5'd9, 2'b00);
    drive_cdb(9, 77);
`ifdef DIV_RS_DISPATCH_BYPASS_EN
    #1 check("t5_bypass_ready", bus.dispatch_ready, 1);
    step();
    clear_inputs();
`else
    #1 check("t5_stall", bus.dispatch_ready, 0);
    step();
    bus.cdb_valid = 0;
    drive_disp(5, 1, 0, 77, 1, 0, 5'd9, 2'b00);
    #1 check("t5_retry_ready", bus.dispatch_ready, 1);
    step();
    clear_inputs();
`endif
    step();
    check("t5_issue_valid", bus.issue_valid, 1);
    check("t5_op2", bus.op2, 77);
    drive_cdb(0, 0);
    step();
    clear_inputs();
    step();

    // Reset while an entry sits ISSUED in the issue register.
    drive_disp(1, 1, 0, 2, 1, 0, 5'd4, 2'b01);
    step();
    clear_inputs();
    bus.issue_ready = 0;
    step();
    check("t6_pre_reset_valid", bus.issue_valid, 1);
    do_reset();
    drive_cdb(0, 32'h1234);
    step();
    clear_inputs();
    check("t6_after_old_tag_valid", bus.issue_valid, 0);
    #1 check("t6_after_old_tag_ready", bus.dispatch_ready, 1);
    bus.issue_ready = 1;

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      bus.dispatch_valid     = ($urandom_range(1) == 1);
      bus.op1_value          = $urandom;
      bus.op2_value          = $urandom;
      bus.op1_present        = ($urandom_range(1) == 1);
      bus.op2_present        = ($urandom_range(1) == 1);
      bus.op1_rs_id          = W'($urandom_range(11));
      bus.op2_rs_id          = W'($urandom_range(11));
      bus.result_reg_addr_in = 5'($urandom);
      bus.control_in         = 2'($urandom);
      bus.cdb_valid          = ($urandom_range(1) == 1);
      bus.cdb_rs_id          = W'($urandom_range(11));
      bus.cdb_result         = $urandom;
      bus.issue_ready        = ($urandom_range(3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
